// File: rtl/actuator_if.sv
// Request/drive bundle between the home-automation controller and the actuator driver.
interface actuator_if #(
  parameter int unsigned PWM_BITS = 8
);
  logic                turn_on_lights;
  logic                turn_on_heater;
  logic                lights;
  logic                heater;
  logic [PWM_BITS-1:0] light_duty;
  logic                heater_busy;

  modport master (
    output turn_on_lights, turn_on_heater,
    input  lights, heater, light_duty, heater_busy
  );

  modport slave (
    input  turn_on_lights, turn_on_heater,
    output lights, heater, light_duty, heater_busy
  );
endinterface

// File: rtl/actuator_driver.sv
// Light PWM dimmer with linear fades and anti-short-cycle heater control,
// fed by 2-flop synchronised request levels.
module actuator_driver #(
  parameter int unsigned PWM_BITS         = 8,
  parameter int unsigned FADE_STEP_CYCLES = 4,
  parameter int unsigned HEATER_MIN_ON    = 16,
  parameter int unsigned HEATER_MIN_OFF   = 16,
  parameter int unsigned DWELL_W          = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  actuator_if.slave bus
);

  localparam logic [1:0] ST_OFF     = 2'd0;
  localparam logic [1:0] ST_ON_MIN  = 2'd1;
  localparam logic [1:0] ST_ON      = 2'd2;
  localparam logic [1:0] ST_OFF_MIN = 2'd3;

  localparam int unsigned         PS_W     = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(FADE_STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = DUTY_MAX - PWM_BITS'(1);
  localparam logic [DWELL_W-1:0]  ON_LOAD  = DWELL_W'(HEATER_MIN_ON - 1);
  localparam logic [DWELL_W-1:0]  OFF_LOAD = DWELL_W'(HEATER_MIN_OFF - 1);

  logic [1:0]          lsync_q, lsync_d;
  logic [1:0]          hsync_q, hsync_d;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                lights_q, lights_d;
  logic [1:0]          state_q, state_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                heater_q, heater_d;
  logic                busy_q, busy_d;

  logic light_req_s;
  logic heater_req_s;
  logic fade_tick;

  assign light_req_s  = lsync_q[1];
  assign heater_req_s = hsync_q[1];
  assign fade_tick    = (ps_q == PS_LAST);

  // Synchronisers, fade ramp and PWM comparator
  always_comb begin
    lsync_d = {lsync_q[0], bus.turn_on_lights};
    hsync_d = {hsync_q[0], bus.turn_on_heater};
    ps_d    = fade_tick ? '0 : ps_q + PS_W'(1);
    pwm_d   = (pwm_q == PWM_LAST) ? '0 : pwm_q + PWM_BITS'(1);
    duty_d  = duty_q;
    if (fade_tick) begin
      if (light_req_s && (duty_q != DUTY_MAX)) begin
        duty_d = duty_q + PWM_BITS'(1);
      end else if (!light_req_s && (duty_q != '0)) begin
        duty_d = duty_q - PWM_BITS'(1);
      end
    end
    lights_d = (pwm_q < duty_q);
  end

  // Heater dwell FSM; request level is only sampled outside the lockout states
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    case (state_q)
      ST_OFF: begin
        if (heater_req_s) begin
          state_d = ST_ON_MIN;
          dwell_d = ON_LOAD;
        end
      end
      ST_ON_MIN: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end else if (heater_req_s) begin
          state_d = ST_ON;
        end else begin
          state_d = ST_OFF_MIN;
          dwell_d = OFF_LOAD;
        end
      end
      ST_ON: begin
        if (!heater_req_s) begin
          state_d = ST_OFF_MIN;
          dwell_d = OFF_LOAD;
        end
      end
      ST_OFF_MIN: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end else if (heater_req_s) begin
          state_d = ST_ON_MIN;
          dwell_d = ON_LOAD;
        end else begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        dwell_d = '0;
      end
    endcase
    heater_d = (state_d == ST_ON_MIN) || (state_d == ST_ON);
    busy_d   = (state_d == ST_ON_MIN) || (state_d == ST_OFF_MIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsync_q  <= '0;
      hsync_q  <= '0;
      ps_q     <= '0;
      pwm_q    <= '0;
      duty_q   <= '0;
      lights_q <= 1'b0;
      state_q  <= ST_OFF;
      dwell_q  <= '0;
      heater_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      lsync_q  <= lsync_d;
      hsync_q  <= hsync_d;
      ps_q     <= ps_d;
      pwm_q    <= pwm_d;
      duty_q   <= duty_d;
      lights_q <= lights_d;
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      heater_q <= heater_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.lights      = lights_q;
  assign bus.heater      = heater_q;
  assign bus.light_duty  = duty_q;
  assign bus.heater_busy = busy_q;

endmodule

// File: tb/tb_actuator_driver.sv
// Scoreboard bench for actuator_driver: directed phases plus random request levels,
// checked cycle by cycle against a time-based reference model.
module tb_actuator_driver;

  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned FADE     = 4;
  localparam int unsigned MIN_ON   = 16;
  localparam int unsigned MIN_OFF  = 16;
  localparam int unsigned MAXD     = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  actuator_if #(.PWM_BITS(PWM_BITS)) bus ();

  actuator_driver #(
    .PWM_BITS(PWM_BITS),
    .FADE_STEP_CYCLES(FADE),
    .HEATER_MIN_ON(MIN_ON),
    .HEATER_MIN_OFF(MIN_OFF),
    .DWELL_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic        lights;
    logic        heater;
    logic        busy;
    int unsigned duty;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: edge count since reset, duty level, heater level and lockout end time
  int unsigned m_k;
  int unsigned m_duty;
  int unsigned m_lock_end;
  bit          m_on;
  bit [1:0]    dl_l;
  bit [1:0]    dl_h;

  bit          win_en = 1'b0;
  int unsigned win_cnt;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_k        = 0;
    m_duty     = 0;
    m_lock_end = 0;
    m_on       = 1'b0;
    dl_l       = '0;
    dl_h       = '0;
  endtask

  // Called at a falling edge: apply inputs, predict the next rising edge, move to next falling edge
  task automatic step(input bit l, input bit h);
    exp_t e;
    bit   rl;
    bit   rh;
    bus.turn_on_lights = l;
    bus.turn_on_heater = h;
    rl   = dl_l[1];
    rh   = dl_h[1];
    dl_l = {dl_l[0], l};
    dl_h = {dl_h[0], h};
    m_k++;
    e.lights = (((m_k - 1) % MAXD) < m_duty);
    if ((m_k % FADE) == 0) begin
      if (rl && (m_duty < MAXD)) m_duty++;
      else if (!rl && (m_duty > 0)) m_duty--;
    end
    if ((m_k >= m_lock_end) && (rh != m_on)) begin
      m_on       = rh;
      m_lock_end = m_k + (rh ? MIN_ON : MIN_OFF);
    end
    e.heater = m_on;
    e.busy   = (m_k < m_lock_end);
    e.duty   = m_duty;
    exp_q.push_back(e);
    if (win_en) win_cnt += 32'(bus.lights);
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0) && (guard < 20)) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drain", 32'(exp_q.size()), 0);
  endtask

  // Monitor: outputs are presented every cycle; compare just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (exp_q.size() != 0)) begin
        e = exp_q.pop_front();
        check("lights",      32'(bus.lights),      32'(e.lights));
        check("heater",      32'(bus.heater),      32'(e.heater));
        check("heater_busy", 32'(bus.heater_busy), 32'(e.busy));
        check("light_duty",  32'(bus.light_duty),  e.duty);
      end
    end
  end

  initial begin
    int          guard;
    int unsigned hl;
    int unsigned hh;
    bit          rl;
    bit          rh;

    rst_n              = 1'b0;
    bus.turn_on_lights = 1'b0;
    bus.turn_on_heater = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_lights",      32'(bus.lights),      0);
    check("reset_heater",      32'(bus.heater),      0);
    check("reset_light_duty",  32'(bus.light_duty),  0);
    check("reset_heater_busy", 32'(bus.heater_busy), 0);
    rst_n = 1'b1;

    // Single-cycle heater request: full on-dwell then full off-dwell
    step(1'b0, 1'b1);
    repeat (45) step(1'b0, 1'b0);

    // Short-cycle guard: second request falls inside the off-dwell
    repeat (20) step(1'b0, 1'b1);
    repeat (5)  step(1'b0, 1'b0);
    repeat (5)  step(1'b0, 1'b1);
    repeat (40) step(1'b0, 1'b0);

    // Fade up with heater on until duty 100, then reset mid-operation
    guard = 0;
    while ((m_duty < 100) && (guard < 2000)) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check("duty_at_100", 32'(bus.light_duty), 100);
    check("heater_on_before_reset", 32'(bus.heater), 1);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_lights",      32'(bus.lights),      0);
    check("async_rst_heater",      32'(bus.heater),      0);
    check("async_rst_light_duty",  32'(bus.light_duty),  0);
    check("async_rst_heater_busy", 32'(bus.heater_busy), 0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Fade up again to 100, then reverse down to 0 and hold
    guard = 0;
    while ((m_duty < 100) && (guard < 2000)) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check("duty_at_100_again", 32'(bus.light_duty), 100);
    repeat (420) step(1'b0, 1'b1);
    win_cnt = 0;
    win_en  = 1'b1;
    repeat (MAXD) step(1'b0, 1'b1);
    win_en  = 1'b0;
    check("pwm_window_duty0", win_cnt, 0);
    check("duty_floor", 32'(bus.light_duty), 0);

    // Full fade up, saturate at MAX
    repeat (1030) step(1'b1, 1'b0);
    win_cnt = 0;
    win_en  = 1'b1;
    repeat (MAXD) step(1'b1, 1'b0);
    win_en  = 1'b0;
    check("pwm_window_dutymax", win_cnt, MAXD);
    check("duty_ceiling", 32'(bus.light_duty), MAXD);

    // Random request levels with random hold lengths
    hl = 0;
    hh = 0;
    rl = 1'b0;
    rh = 1'b0;
    repeat (3000) begin
      if (hl == 0) begin
        rl = bit'($urandom_range(0, 1));
        hl = $urandom_range(1, 80);
      end
      if (hh == 0) begin
        rh = bit'($urandom_range(0, 1));
        hh = $urandom_range(1, 40);
      end
      hl--;
      hh--;
      step(rl, rh);
    end

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
